// File: rtl/vec_check_pkg.sv
// vec_check_pkg: shared state encoding, default counter width and saturating increment
package vec_check_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, DONE = 2'd2} state_t;
  localparam int ERR_W_DEF = 16;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max;
    max = 32'hffff_ffff >> (32 - w);
    return (v >= max) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/delay_pipe.sv
// delay_pipe: DEPTH-stage {valid, data} shift register, reset clears valid bits only
module delay_pipe #(
  parameter int DEPTH = 1,
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         pending
);
  logic [DEPTH-1:0] vld;
  logic [W-1:0]     dat [DEPTH];
  always_ff @(posedge clock) begin
    if (reset) vld <= '0;
    else vld <= (vld << 1) | DEPTH'(in_valid);
  end
  always_ff @(posedge clock) begin
    dat[0] <= in_data;
    for (int i = 1; i < DEPTH; i++) dat[i] <= dat[i-1];
  end
  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];
  assign pending   = |(vld << 1);
endmodule

// File: rtl/vec_check_i8.sv
// vec_check_i8: streams (a, b, expected) vectors into a DUT and checks its result after a fixed latency
module vec_check_i8
  import vec_check_pkg::*;
#(
  parameter int W = 8,
  parameter int LATENCY = 0,
  parameter int ERR_W = ERR_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic             vec_last,
  input  logic [W-1:0]     vec_a,
  input  logic [W-1:0]     vec_b,
  input  logic [W-1:0]     vec_exp,
  output logic [W-1:0]     dut_a,
  output logic [W-1:0]     dut_b,
  input  logic [W-1:0]     dut_y,
  output logic             fail,
  output logic             finish,
  output logic [ERR_W-1:0] err_count,
  output logic [ERR_W-1:0] chk_count
);
  state_t state, state_n;
  logic acc, p_valid, pending, miss;
  logic [W-1:0] p_exp;
  assign vec_ready = !reset && state == RUN;
  assign acc       = vec_valid && vec_ready;
  assign finish    = state == DONE;
  assign miss      = p_valid && dut_y != p_exp;
  always_comb begin
    state_n = state;
    state_n = (state == RUN && acc && vec_last) ? DRAIN :
              (state == DRAIN && !pending)      ? DONE  : state;
  end
  always_ff @(posedge clock) begin
    if (reset) state <= RUN;
    else state <= state_n;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      dut_a <= '0;
      dut_b <= '0;
    end else if (acc) begin
      dut_a <= vec_a;
      dut_b <= vec_b;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      fail      <= 1'b0;
      err_count <= '0;
      chk_count <= '0;
    end else if (p_valid) begin
      chk_count <= ERR_W'(sat_inc(32'(chk_count), ERR_W));
      if (miss) begin
        err_count <= ERR_W'(sat_inc(32'(err_count), ERR_W));
        fail      <= 1'b1;
      end
    end
  end
  delay_pipe #(.DEPTH(LATENCY + 1), .W(W)) u_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (acc),
    .in_data   (vec_exp),
    .out_valid (p_valid),
    .out_data  (p_exp),
    .pending   (pending)
  );
`ifndef SYNTHESIS
  always @(posedge clock) if (!reset && miss) $display("vec_check_i8: res=%0d exp=%0d differ", $signed(dut_y), $signed(p_exp));
`endif
endmodule

// File: doc/vec_check_i8.md
Name: vec_check_i8

Overview:
- Stimulus/checker stage for single-op CI benches. It sits on both sides of a DUT such as an 8-bit multiplier.
- Accepts (a, b, expected) vectors over a valid/ready stream and drives the DUT operands.
- After a fixed DUT latency it compares the DUT result against the expected value and raises sticky fail/finish flags for the top-level CI harness.
- Replaces hand-written per-test step case statements.

Parameters:
- W, 8, operand/result width in bits.
- LATENCY, 0, DUT pipeline depth in clock edges from operand change to valid y (0 = combinational DUT).
- ERR_W, 16, width of error and check counters.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; clears all state.
- vec_valid  in  1  vector available.
- vec_ready  out  1  block accepts a vector this cycle.
- vec_last  in  1  marks final vector; qualified by vec_valid.
- vec_a  in  W  operand a.
- vec_b  in  W  operand b.
- vec_exp  in  W  expected DUT result.
- dut_a  out  W  registered operand a to DUT.
- dut_b  out  W  registered operand b to DUT.
- dut_y  in  W  DUT result.
- fail  out  1  sticky; set on first mismatch.
- finish  out  1  sticky; set when all checks are complete.
- err_count  out  ERR_W  mismatches seen; saturating.
- chk_count  out  ERR_W  comparisons performed; saturating.

Behaviour:
- Reset (sync, active-high) forces:
  - state=RUN;
  - vec_ready=0 during the reset cycle, 1 from the first non-reset cycle;
  - dut_a=dut_b=0;
  - fail=finish=0;
  - err_count=chk_count=0;
  - check pipeline valid bits all 0.
- Reset asserted mid-operation aborts in-flight checks with no compare. The same clearing applies.
- States:
  - RUN: vec_ready=1. Accept occurs on an edge where vec_valid&vec_ready. An accept with vec_last=1 moves to DRAIN.
  - DRAIN: vec_ready=0. Stays until the check pipeline holds no valid entries, then moves to DONE.
  - DONE: vec_ready=0; finish=1 from the edge entering DONE. Terminal until reset.
- Accept at edge E:
  - dut_a/dut_b load vec_a/vec_b at E and hold until the next accept.
  - {1, vec_exp} enters a (LATENCY+1)-deep valid/expected shift pipeline.
- Compare at edge E+1+LATENCY, when the pipeline output is valid:
  - dut_y sampled at that edge vs the delayed expected value, W-bit exact equality. Width is wrap-around (modulo 2^W); no sign semantics.
  - chk_count+1.
  - On mismatch: err_count+1, fail<=1, and a simulation-only $display reporting res and exp as signed.
- Counters saturate at 2^ERR_W-1 with no wrap.
- Back-to-back accepts are allowed every cycle; throughput is 1 vector/cycle.
- Idle cycles: the pipeline shifts in valid=0 and no compare occurs.
- A DRAIN-to-DONE transition and the final compare on the same edge are legal. finish and any final fail/err update become visible together.
- fail never clears except by reset. A mismatch after finish is impossible because the pipeline is empty in DONE.
- vec_valid while vec_ready=0 is ignored, with no side effects.
- LATENCY=0: the compare uses dut_y one edge after the accept, driven combinationally from the registered dut_a/dut_b.

Decomposition:
- Shared package vec_check_pkg:
  - state encodings RUN=2'd0, DRAIN=2'd1, DONE=2'd2;
  - default ERR_W;
  - the saturating-increment function.
- One sub-module: delay_pipe (parameters DEPTH, W). Shift register of {valid, data} with synchronous reset clearing valid bits only.
- The FSM, operand registers, comparator and counters live in vec_check_i8.

Test Plan:
- Single vector a=9, b=3, exp=27, last=1, with a mul_i8_i8_i8 DUT at LATENCY=0:
  - dut_a=9, dut_b=3 one edge after accept;
  - compare next edge;
  - finish=1, fail=0, chk_count=1, err_count=0.
- Wrap check: a=16, b=17, exp=16, last=1 (272 mod 256) -> fail=0, finish=1.
- Mismatch: vectors (9,3,27), (2,5,11), (4,4,16, last) streamed back-to-back -> fail=1 after the second compare, err_count=1, chk_count=3, finish=1.
- LATENCY=2 DUT model with 3 back-to-back vectors -> compares land at accept+3 edges each; no compares on idle cycles; finish asserted exactly when the last compare occurs.
- Backpressure/ignore: after DONE, vec_valid=1 with exp=0xFF for 5 cycles -> vec_ready=0, counters and flags unchanged.
- Mid-run reset: assert reset for 1 cycle while 2 checks are in flight (LATENCY=2) -> flags and counters are 0 next cycle, no stale compare, and a new single correct vector finishes with fail=0, chk_count=1.
